// File: rtl/hwpe_cmd_pkg.sv
// hwpe_cmd_pkg: shared definitions for the HWPE command front-end.
//   - custom-0 opcode and funct7 command encodings
//   - instruction field positions
//   - cfg1 field layout and slice helpers
//   - command FSM state type
package hwpe_cmd_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [6:0] {
    F_WFAD   = 7'd1,
    F_WCFG   = 7'd2,
    F_MATRIX = 7'd4,
    F_WACC   = 7'd8,
    F_RACC   = 7'd16,
    F_RELU   = 7'd32,
    F_RESET  = 7'd64
  } funct7_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int RDF_LSB    = 7;
  localparam int RS1F_LSB   = 15;
  localparam int RS2F_LSB   = 20;
  localparam int FIELD_W    = 5;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_W   = 7;

  // cfg1 = {K_count, AccReg_shift, Kernel_333, Layer_type, Data_type, Kernel_size}
  localparam int CFG1_KSIZE_LSB  = 0;
  localparam int CFG1_KSIZE_W    = 4;
  localparam int CFG1_DTYPE_LSB  = 4;
  localparam int CFG1_DTYPE_W    = 2;
  localparam int CFG1_LTYPE_LSB  = 6;
  localparam int CFG1_LTYPE_W    = 2;
  localparam int CFG1_K333_LSB   = 8;
  localparam int CFG1_SHIFT_LSB  = 9;
  localparam int CFG1_SHIFT_W    = 7;
  localparam int CFG1_KCOUNT_LSB = 16;
  localparam int CFG1_KCOUNT_W   = 16;

  function automatic logic [CFG1_KSIZE_W-1:0] cfg1_kernel_size(input logic [31:0] cfg1);
    return cfg1[CFG1_KSIZE_LSB +: CFG1_KSIZE_W];
  endfunction

  function automatic logic [CFG1_DTYPE_W-1:0] cfg1_data_type(input logic [31:0] cfg1);
    return cfg1[CFG1_DTYPE_LSB +: CFG1_DTYPE_W];
  endfunction

  function automatic logic [CFG1_LTYPE_W-1:0] cfg1_layer_type(input logic [31:0] cfg1);
    return cfg1[CFG1_LTYPE_LSB +: CFG1_LTYPE_W];
  endfunction

  function automatic logic cfg1_kernel_333(input logic [31:0] cfg1);
    return cfg1[CFG1_K333_LSB];
  endfunction

  function automatic logic [CFG1_SHIFT_W-1:0] cfg1_acc_shift(input logic [31:0] cfg1);
    return cfg1[CFG1_SHIFT_LSB +: CFG1_SHIFT_W];
  endfunction

  function automatic logic [CFG1_KCOUNT_W-1:0] cfg1_k_count(input logic [31:0] cfg1);
    return cfg1[CFG1_KCOUNT_LSB +: CFG1_KCOUNT_W];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/hwpe_cfg_regs.sv
// hwpe_cfg_regs: layer configuration and FMEM base-address register file.
// Ports:
//   clk, rst         clock, async active-high reset
//   clr              synchronous clear of every register
//   cfg_we           load cfg0 <= wd_lo, cfg1 <= wd_hi
//   mat_we           load mat_vrs1 <= wd_lo, mat_vrs2 <= wd_hi
//   base_we          load base[base_idx] <= wd_lo, base[base_idx+1] <= wd_hi
//   base_idx         even base-register index of the pair being written
//   wd_lo, wd_hi     write data (rs1, rs2)
//   cfg0_o, cfg1_o, mat_vrs1_o, mat_vrs2_o, base_addr_o   register contents
module hwpe_cfg_regs
  import hwpe_cmd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int N_BASE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cfg_we,
  input  logic                     mat_we,
  input  logic                     base_we,
  input  logic [$clog2(N_BASE)-1:0] base_idx,
  input  logic [XLEN-1:0]          wd_lo,
  input  logic [XLEN-1:0]          wd_hi,
  output logic [XLEN-1:0]          cfg0_o,
  output logic [XLEN-1:0]          cfg1_o,
  output logic [XLEN-1:0]          mat_vrs1_o,
  output logic [XLEN-1:0]          mat_vrs2_o,
  output logic [N_BASE*XLEN-1:0]   base_addr_o
);

  localparam int BW = $clog2(N_BASE);

  logic [XLEN-1:0] base_q [N_BASE];
  logic [BW-1:0]   base_idx_hi;

  assign base_idx_hi = base_idx + BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg0_o     <= '0;
      cfg1_o     <= '0;
      mat_vrs1_o <= '0;
      mat_vrs2_o <= '0;
      for (int i = 0; i < N_BASE; i++) base_q[i] <= '0;
    end else if (clr) begin
      cfg0_o     <= '0;
      cfg1_o     <= '0;
      mat_vrs1_o <= '0;
      mat_vrs2_o <= '0;
      for (int i = 0; i < N_BASE; i++) base_q[i] <= '0;
    end else begin
      if (cfg_we) begin
        cfg0_o <= wd_lo;
        cfg1_o <= wd_hi;
      end
      if (mat_we) begin
        mat_vrs1_o <= wd_lo;
        mat_vrs2_o <= wd_hi;
      end
      if (base_we) begin
        base_q[base_idx]    <= wd_lo;
        base_q[base_idx_hi] <= wd_hi;
      end
    end
  end

  for (genvar g = 0; g < N_BASE; g++) begin : g_flat
    assign base_addr_o[g*XLEN +: XLEN] = base_q[g];
  end

endmodule

// File: rtl/hwpe_cmd_dec.sv
// hwpe_cmd_dec: HWPE command front-end. Accepts {inst, rs1, rs2} custom-0
// commands, decodes funct7, owns the layer configuration registers and
// dispatches one-cycle strobes to the conv engine, AccReg port and ReLU writer.
// AccReg reads return on the resp_* channel.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cmd_valid/ready, cmd_inst/rs1/rs2 command channel
//   resp_valid/ready, resp_data       AccReg read response channel
//   cfg0_o, cfg1_o, mat_vrs1_o, mat_vrs2_o, base_addr_o   configuration
//   eng_start, eng_busy, eng_tile_rdy, eng_advance        conv engine
//   acc_we, acc_re, acc_row, acc_pe, acc_wdata, acc_rdata AccReg port
//   relu_en, relu_addr                ReLU writer
//   soft_rst                          datapath soft reset pulse
//   err_o                             sticky illegal-command flag
//
// state   | meaning
// IDLE    | ready for a command (subject to engine gating)
// RD_WAIT | acc_re issued; AccReg data returns the following cycle
// RESP    | resp_valid held until resp_ready
module hwpe_cmd_dec
  import hwpe_cmd_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int N_ROW  = 8,
  parameter int N_PE   = 16,
  parameter int N_BASE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [XLEN-1:0]           cmd_inst,
  input  logic [XLEN-1:0]           cmd_rs1,
  input  logic [XLEN-1:0]           cmd_rs2,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_data,
  output logic [XLEN-1:0]           cfg0_o,
  output logic [XLEN-1:0]           cfg1_o,
  output logic [XLEN-1:0]           mat_vrs1_o,
  output logic [XLEN-1:0]           mat_vrs2_o,
  output logic [N_BASE*XLEN-1:0]    base_addr_o,
  output logic                      eng_start,
  input  logic                      eng_busy,
  input  logic                      eng_tile_rdy,
  output logic                      eng_advance,
  output logic                      acc_we,
  output logic                      acc_re,
  output logic [$clog2(N_ROW)-1:0]  acc_row,
  output logic [$clog2(N_PE)-1:0]   acc_pe,
  output logic [XLEN-1:0]           acc_wdata,
  input  logic [XLEN-1:0]           acc_rdata,
  output logic                      relu_en,
  output logic [XLEN-1:0]           relu_addr,
  output logic                      soft_rst,
  output logic                      err_o
);

  localparam int RW = $clog2(N_ROW);
  localparam int PW = $clog2(N_PE);
  localparam int BW = $clog2(N_BASE);
  localparam logic [FIELD_W-1:0] RDF_LIM = FIELD_W'(N_BASE - 1);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT7_W-1:0] funct7;
  logic [FIELD_W-1:0]  rs2f, rs1f, rdf;

  assign opcode = cmd_inst[OPCODE_LSB +: OPCODE_W];
  assign funct7 = cmd_inst[FUNCT7_LSB +: FUNCT7_W];
  assign rs2f   = cmd_inst[RS2F_LSB +: FIELD_W];
  assign rs1f   = cmd_inst[RS1F_LSB +: FIELD_W];
  assign rdf    = cmd_inst[RDF_LSB +: FIELD_W];

  logic unused_bits;
  assign unused_bits = ^{cmd_inst[14:12], rs1f[3]};

  logic   is_legal, gate_ok, accept;
  logic   do_reset, do_wcfg, do_wfad, do_matrix;
  logic   rd_adv_q, relu_adv_q;
  state_e state_q, state_d;

  always_comb begin
    is_legal = 1'b0;
    if (opcode == OPCODE_CUSTOM0) begin
      case (funct7)
        F_WFAD:   is_legal = (rdf[0] == 1'b0) && (rdf < RDF_LIM);
        F_WCFG, F_MATRIX, F_WACC, F_RACC, F_RELU, F_RESET: is_legal = 1'b1;
        default:  is_legal = 1'b0;
      endcase
    end
  end

  // Illegal commands are never stalled: they only raise err_o.
  always_comb begin
    gate_ok = 1'b1;
    if (is_legal) begin
      case (funct7)
        F_WCFG, F_WFAD, F_WACC, F_MATRIX: gate_ok = !eng_busy;
        F_RACC, F_RELU:                   gate_ok = !eng_busy || eng_tile_rdy;
        default:                          gate_ok = 1'b1;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && gate_ok;
  assign accept    = cmd_valid && cmd_ready;

  assign do_reset  = accept && is_legal && (funct7 == F_RESET);
  assign do_wcfg   = accept && is_legal && (funct7 == F_WCFG);
  assign do_wfad   = accept && is_legal && (funct7 == F_WFAD);
  assign do_matrix = accept && is_legal && (funct7 == F_MATRIX);

  hwpe_cfg_regs #(
    .XLEN   (XLEN),
    .N_BASE (N_BASE)
  ) u_cfg_regs (
    .clk         (clk),
    .rst         (rst),
    .clr         (do_reset),
    .cfg_we      (do_wcfg),
    .mat_we      (do_matrix),
    .base_we     (do_wfad),
    .base_idx    (rdf[BW-1:0]),
    .wd_lo       (cmd_rs1),
    .wd_hi       (cmd_rs2),
    .cfg0_o      (cfg0_o),
    .cfg1_o      (cfg1_o),
    .mat_vrs1_o  (mat_vrs1_o),
    .mat_vrs2_o  (mat_vrs2_o),
    .base_addr_o (base_addr_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // RD_WAIT spans two cycles: the acc_re cycle, then the cycle in which
  // acc_rdata is valid and gets captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && is_legal && (funct7 == F_RACC)) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (!acc_re) state_d = ST_RESP;
      ST_RESP:    if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_rst   <= 1'b0;
      eng_start  <= 1'b0;
      acc_we     <= 1'b0;
      acc_re     <= 1'b0;
      relu_en    <= 1'b0;
      relu_adv_q <= 1'b0;
      rd_adv_q   <= 1'b0;
      acc_row    <= '0;
      acc_pe     <= '0;
      acc_wdata  <= '0;
      relu_addr  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      err_o      <= 1'b0;
    end else begin
      soft_rst   <= 1'b0;
      eng_start  <= 1'b0;
      acc_we     <= 1'b0;
      acc_re     <= 1'b0;
      relu_en    <= 1'b0;
      relu_adv_q <= 1'b0;
      if (accept) begin
        if (!is_legal) begin
          err_o <= 1'b1;
        end else begin
          case (funct7)
            F_RESET: begin
              soft_rst <= 1'b1;
              err_o    <= 1'b0;
            end
            F_MATRIX: eng_start <= 1'b1;
            F_WACC: begin
              acc_we    <= 1'b1;
              acc_row   <= rdf[RW-1:0];
              acc_pe    <= rs2f[PW-1:0];
              acc_wdata <= cmd_rs1;
            end
            F_RACC: begin
              acc_re   <= 1'b1;
              acc_row  <= rs1f[RW-1:0];
              acc_pe   <= rs2f[PW-1:0];
              rd_adv_q <= rs1f[4];
            end
            F_RELU: begin
              relu_en    <= 1'b1;
              acc_row    <= rs2f[RW-1:0];
              relu_addr  <= cmd_rs1;
              relu_adv_q <= rs2f[4];
            end
            default: ;
          endcase
        end
      end
      if ((state_q == ST_RD_WAIT) && !acc_re) begin
        resp_valid <= 1'b1;
        resp_data  <= acc_rdata;
      end
      if ((state_q == ST_RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        rd_adv_q   <= 1'b0;
      end
    end
  end

  // The RACC advance must coincide with the response handshake, so that term
  // is combinational on resp_ready.
  assign eng_advance = relu_adv_q || ((state_q == ST_RESP) && resp_ready && rd_adv_q);

endmodule

// File: tb/tb_hwpe_cmd_dec.sv
module tb_hwpe_cmd_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  cmd_inst, cmd_rs1, cmd_rs2;
  logic         resp_valid, resp_ready;
  logic [31:0]  resp_data;
  logic [31:0]  cfg0_o, cfg1_o, mat_vrs1_o, mat_vrs2_o;
  logic [255:0] base_addr_o;
  logic         eng_start, eng_busy, eng_tile_rdy, eng_advance;
  logic         acc_we, acc_re;
  logic [2:0]   acc_row;
  logic [3:0]   acc_pe;
  logic [31:0]  acc_wdata;
  logic [31:0]  acc_rdata = 32'h0;
  logic         relu_en;
  logic [31:0]  relu_addr;
  logic         soft_rst, err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hwpe_cmd_dec dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_inst(cmd_inst), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cfg0_o(cfg0_o), .cfg1_o(cfg1_o), .mat_vrs1_o(mat_vrs1_o), .mat_vrs2_o(mat_vrs2_o),
    .base_addr_o(base_addr_o),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_tile_rdy(eng_tile_rdy),
    .eng_advance(eng_advance),
    .acc_we(acc_we), .acc_re(acc_re), .acc_row(acc_row), .acc_pe(acc_pe),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
    .relu_en(relu_en), .relu_addr(relu_addr),
    .soft_rst(soft_rst), .err_o(err_o)
  );

  // AccReg stand-in: write on acc_we, read data valid the cycle after acc_re.
  logic [31:0] acc_mem [8][16];
  always @(posedge clk) begin
    if (acc_we) acc_mem[acc_row][acc_pe] <= acc_wdata;
    if (acc_re) acc_rdata <= acc_mem[acc_row][acc_pe];
  end

  // {soft_rst, eng_start, acc_we, acc_re, relu_en, eng_advance}
  logic [5:0] strb;
  assign strb = {soft_rst, eng_start, acc_we, acc_re, relu_en, eng_advance};

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [4:0] rd);
    return {f7, r2, r1, 3'b000, rd, 7'b0001011};
  endfunction

  function automatic logic [31:0] base_at(input int i);
    return base_addr_o[32*i +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a command from posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    int n;
    n = 0;
    cmd_inst = i; cmd_rs1 = r1; cmd_rs2 = r2; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: inst 0x%08h never accepted", i);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (!resp_valid && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (!resp_valid) begin
      failures++;
      $display("FAIL %s: resp_valid got 0 expected 1 within 10 cycles", name);
    end
  endtask

  typedef struct {
    logic [31:0] inst, rs1, rs2;
    logic [5:0]  strb;
    logic [31:0] cfg0, cfg1, vrs1, b2, b3, b7;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_inst = 32'h0; cmd_rs1 = 32'h0; cmd_rs2 = 32'h0;
    resp_ready = 1'b0; eng_busy = 1'b0; eng_tile_rdy = 1'b0;

    vecs[0] = '{mk(7'd64, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0, 6'b100000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{mk(7'd2, 5'd0, 5'd0, 5'd0), 32'h00C0_0006, 32'h0002_1009, 6'b000000,
                32'h00C0_0006, 32'h0002_1009, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[2] = '{mk(7'd1, 5'd0, 5'd0, 5'd2), 32'h30, 32'h430, 6'b000000,
                32'h00C0_0006, 32'h0002_1009, 32'h0, 32'h30, 32'h430, 32'h0, 1'b0};
    vecs[3] = '{mk(7'd1, 5'd0, 5'd0, 5'd7), 32'hAAAA, 32'hBBBB, 6'b000000,
                32'h00C0_0006, 32'h0002_1009, 32'h0, 32'h30, 32'h430, 32'h0, 1'b1};
    vecs[4] = '{32'h0000_0033, 32'h1, 32'h2, 6'b000000,
                32'h00C0_0006, 32'h0002_1009, 32'h0, 32'h30, 32'h430, 32'h0, 1'b1};
    vecs[5] = '{mk(7'd64, 5'd0, 5'd0, 5'd0), 32'h0, 32'h0, 6'b100000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[6] = '{mk(7'd1, 5'd0, 5'd0, 5'd6), 32'h111, 32'h777, 6'b000000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h777, 1'b0};
    vecs[7] = '{mk(7'd3, 5'd0, 5'd0, 5'd0), 32'h5, 32'h6, 6'b000000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h777, 1'b1};
    vecs[8] = '{mk(7'd8, 5'd2, 5'd0, 5'd1), 32'h1234_5678, 32'h0, 6'b001000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h777, 1'b1};
    vecs[9] = '{mk(7'd4, 5'd0, 5'd0, 5'd0), 32'h0001_0002, 32'h5, 6'b010000,
                32'h0, 32'h0, 32'h0001_0002, 32'h0, 32'h0, 32'h777, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    cmd_inst = mk(7'd2, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_cfg0", cfg0_o, 32'h0);
    chk("rst_cfg1", cfg1_o, 32'h0);
    chk("rst_base_any", 32'(|base_addr_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_strb", 32'(strb), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      issue(vecs[k].inst, vecs[k].rs1, vecs[k].rs2);
      chk($sformatf("v%0d_strb", k), 32'(strb), 32'(vecs[k].strb));
      chk($sformatf("v%0d_cfg0", k), cfg0_o, vecs[k].cfg0);
      chk($sformatf("v%0d_cfg1", k), cfg1_o, vecs[k].cfg1);
      chk($sformatf("v%0d_vrs1", k), mat_vrs1_o, vecs[k].vrs1);
      chk($sformatf("v%0d_base2", k), base_at(2), vecs[k].b2);
      chk($sformatf("v%0d_base3", k), base_at(3), vecs[k].b3);
      chk($sformatf("v%0d_base7", k), base_at(7), vecs[k].b7);
      chk($sformatf("v%0d_err", k), 32'(err_o), 32'(vecs[k].err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_strb_off", k), 32'(strb), 32'h0);
    end
    chk("matrix_vrs2", mat_vrs2_o, 32'h5);

    // WACC then RACC with a stalled response
    issue(mk(7'd8, 5'd9, 5'd0, 5'd5), 32'hDEAD_BEEF, 32'h0);
    chk("wacc_row", 32'(acc_row), 32'h5);
    chk("wacc_pe", 32'(acc_pe), 32'h9);
    @(posedge clk); #1;
    issue(mk(7'd16, 5'd9, 5'd5, 5'd0), 32'h0, 32'h0);
    chk("racc_re", 32'(acc_re), 32'h1);
    chk("racc_row", 32'(acc_row), 32'h5);
    chk("racc_pe", 32'(acc_pe), 32'h9);
    chk("racc_rdwait_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    chk("racc_re_off", 32'(acc_re), 32'h0);
    wait_resp("racc_resp");
    chk("racc_data", resp_data, 32'hDEAD_BEEF);
    cmd_inst = mk(7'd2, 5'd0, 5'd0, 5'd0); cmd_rs1 = 32'h99; cmd_rs2 = 32'h98;
    cmd_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), 32'(resp_valid), 32'h1);
      chk($sformatf("hold%0d_data", c), resp_data, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d_ready", c), 32'(cmd_ready), 32'h0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("hold_cfg0_unchanged", cfg0_o, 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("racc_no_adv", 32'(eng_advance), 32'h0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("racc_drained", 32'(resp_valid), 32'h0);
    chk("racc_idle_ready", 32'(cmd_ready), 32'h1);

    // MATRIX, then RACC gated by eng_busy / eng_tile_rdy with advance
    issue(mk(7'd8, 5'd15, 5'd0, 5'd7), 32'hCAFE_F00D, 32'h0);
    @(posedge clk); #1;
    issue(mk(7'd4, 5'd0, 5'd0, 5'd0), 32'h0001_0002, 32'h3);
    chk("mtx_start", 32'(eng_start), 32'h1);
    chk("mtx_vrs2", mat_vrs2_o, 32'h3);
    @(posedge clk); #1;
    chk("mtx_start_off", 32'(eng_start), 32'h0);
    eng_busy = 1'b1;
    cmd_inst = mk(7'd2, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("busy_wcfg_stall", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    cmd_inst = mk(7'd16, 5'd15, 5'b10111, 5'd0);
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("busy_racc_stall%0d", c), 32'(cmd_ready), 32'h0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("busy_no_re", 32'(acc_re), 32'h0);
    cmd_inst = mk(7'd64, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("busy_reset_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    eng_tile_rdy = 1'b1;
    issue(mk(7'd16, 5'd15, 5'b10111, 5'd0), 32'h0, 32'h0);
    chk("tile_racc_re", 32'(acc_re), 32'h1);
    chk("tile_racc_row", 32'(acc_row), 32'h7);
    chk("tile_racc_pe", 32'(acc_pe), 32'hF);
    wait_resp("tile_racc_resp");
    chk("tile_racc_data", resp_data, 32'hCAFE_F00D);
    chk("tile_adv_before_hs", 32'(eng_advance), 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("tile_adv_hs", 32'(eng_advance), 32'h1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("tile_adv_off", 32'(eng_advance), 32'h0);
    chk("tile_drained", 32'(resp_valid), 32'h0);
    eng_busy = 1'b0; eng_tile_rdy = 1'b0;

    // RELU with advance
    issue(mk(7'd32, 5'b10111, 5'd0, 5'd0), 32'd128, 32'h0);
    chk("relu_en", 32'(relu_en), 32'h1);
    chk("relu_addr", relu_addr, 32'd128);
    chk("relu_row", 32'(acc_row), 32'h7);
    chk("relu_adv", 32'(eng_advance), 32'h1);
    @(posedge clk); #1;
    chk("relu_en_off", 32'(relu_en), 32'h0);
    chk("relu_adv_off", 32'(eng_advance), 32'h0);

    // Async reset while a response is pending
    issue(mk(7'd2, 5'd0, 5'd0, 5'd0), 32'h1234, 32'h5678);
    issue(32'h0000_0033, 32'h0, 32'h0);
    chk("pre_rst_err", 32'(err_o), 32'h1);
    chk("pre_rst_cfg0", cfg0_o, 32'h1234);
    issue(mk(7'd16, 5'd9, 5'd5, 5'd0), 32'h0, 32'h0);
    wait_resp("pre_rst_resp");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'h0);
    chk("arst_cfg0", cfg0_o, 32'h0);
    chk("arst_cfg1", cfg1_o, 32'h0);
    chk("arst_vrs1", mat_vrs1_o, 32'h0);
    chk("arst_base_any", 32'(|base_addr_o), 32'h0);
    chk("arst_err", 32'(err_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_inst = mk(7'd2, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("arst_idle_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    issue(32'h0000_0033, 32'h0, 32'h0);
    chk("illegal_err", 32'(err_o), 32'h1);
    chk("illegal_no_strb", 32'(strb), 32'h0);
    chk("illegal_cfg0", cfg0_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
